pc_sequence_ctrl: RTL

//  Controller that sequences the fetch program-counter register each cycle.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequence_ctrl_if.sv | 37 +++
 rtl/pc_seq_drain_cnt.sv | 28 ++
 rtl/pc_sequence_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, PC register commands
// and the drain counter width.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    PUSH   = 2'b10,
    VECTOR = 2'b11
  } pc_seq_state_e;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    INC  = 2'b01,
    LOAD = 2'b10
  } pc_cmd_e;

  // Wide enough for a drain length of up to 15 cycles.
  localparam int DRAIN_W = 4;

endpackage

// File: rtl/pc_sequence_ctrl_if.sv
// Bundle between the PC sequencer and its neighbours (hazard, branch and
// stack units, PC register). The sequencer uses the master side.
interface pc_sequence_ctrl_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] pc_cur;
  logic              hazard_stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              ret_valid;
  logic [ADDR_W-1:0] ret_pc;
  logic              int_req;
  logic              push_ack;
  pc_cmd_e           pc_cmd;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              flush;
  logic              push_req;
  logic [ADDR_W-1:0] push_data;
  logic              int_ack;
  logic              busy;

  modport master (
    input  pc_cur, hazard_stall, branch_taken, branch_target,
           ret_valid, ret_pc, int_req, push_ack,
    output pc_cmd, pc_load_addr, flush, push_req, push_data, int_ack, busy
  );

  modport slave (
    output pc_cur, hazard_stall, branch_taken, branch_target,
           ret_valid, ret_pc, int_req, push_ack,
    input  pc_cmd, pc_load_addr, flush, push_req, push_data, int_ack, busy
  );

endinterface

// File: rtl/pc_seq_drain_cnt.sv
// Loadable down-counter timing the pipeline drain; done is the terminal-count
// compare and the count never wraps below zero.
module pc_seq_drain_cnt
  import pc_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DRAIN_W-1:0] load_val,
  input  logic               dec,
  output logic               done
);

  logic [DRAIN_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !done) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pc_sequence_ctrl.sv
// Fetch PC sequencer: boot load, return reload, stall, branch, increment and
// multi-cycle interrupt entry. Optional interrupt mask: PC_SEQ_INT_MASK_EN.
//
// state  | meaning
// RUN    | normal fetch sequencing, interrupts taken from here
// DRAIN  | flush fetch/decode for DRAIN_CYCLES cycles
// PUSH   | return PC offered to the stack, wait for push_ack
// VECTOR | load INT_VEC, pulse int_ack, clear the pending request
module pc_sequence_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC    = 'h20,
  parameter logic [ADDR_W-1:0] INT_VEC      = 'h0,
  parameter logic [ADDR_W-1:0] PC_LIMIT     = 100,
  parameter int unsigned       DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic reset,
`ifdef PC_SEQ_INT_MASK_EN
  input logic int_en_set,
  input logic int_en_clr,
`endif
  pc_sequence_ctrl_if.master bus
);

  pc_seq_state_e     state, state_nxt;
  pc_cmd_e           cmd;
  logic [ADDR_W-1:0] load_addr;
  logic              flush_q, push_req_q, int_ack_q, int_pend;
  logic [ADDR_W-1:0] push_data_q;
  logic              int_go, take_int, dr_load, dr_dec, dr_done;

`ifdef PC_SEQ_INT_MASK_EN
  logic int_en;

  always_ff @(posedge clk) begin
    if (reset)                int_en <= 1'b0;
    else if (state == VECTOR) int_en <= 1'b0;
    else if (int_en_set)      int_en <= 1'b1;
    else if (int_en_clr)      int_en <= 1'b0;
  end

  assign int_go = (int_pend | bus.int_req) & int_en;
`else
  // The same-cycle request counts so a coincident branch becomes the return PC.
  assign int_go = int_pend | bus.int_req;
`endif

  pc_seq_drain_cnt u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (dr_load),
    .load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
    .dec      (dr_dec),
    .done     (dr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      flush_q     <= 1'b0;
      push_req_q  <= 1'b0;
      int_ack_q   <= 1'b0;
      int_pend    <= 1'b0;
      push_data_q <= '0;
    end else begin
      state      <= state_nxt;
      flush_q    <= (state_nxt == DRAIN);
      push_req_q <= (state_nxt == PUSH);
      int_ack_q  <= (state_nxt == VECTOR);
      int_pend   <= (state == VECTOR) ? bus.int_req : (int_pend | bus.int_req);
      if (take_int)
        push_data_q <= bus.branch_taken ? bus.branch_target : bus.pc_cur;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd       = HOLD;
    load_addr = '0;
    take_int  = 1'b0;
    dr_load   = 1'b0;
    dr_dec    = 1'b0;
    if (reset) begin
      cmd       = LOAD;
      load_addr = RESET_VEC;
    end else begin
      case (state)
        RUN: begin
          if (bus.ret_valid) begin
            cmd       = LOAD;
            load_addr = bus.ret_pc;
          end else if (bus.hazard_stall) begin
            cmd = HOLD;
          end else if (int_go) begin
            take_int  = 1'b1;
            dr_load   = 1'b1;
            state_nxt = DRAIN;
          end else if (bus.branch_taken) begin
            cmd       = LOAD;
            load_addr = bus.branch_target;
          end else if (bus.pc_cur < PC_LIMIT) begin
            cmd = INC;
          end
        end
        DRAIN: begin
          dr_dec = 1'b1;
          if (dr_done) state_nxt = PUSH;
        end
        PUSH: begin
          if (bus.push_ack) state_nxt = VECTOR;
        end
        VECTOR: begin
          cmd       = LOAD;
          load_addr = INT_VEC;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.pc_cmd       = cmd;
  assign bus.pc_load_addr = load_addr;
  assign bus.flush        = flush_q;
  assign bus.push_req     = push_req_q;
  assign bus.push_data    = push_data_q;
  assign bus.int_ack      = int_ack_q;
  assign bus.busy         = (state != RUN);

endmodule
